control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 163 ++++++++++++++++
 tb/tb_control_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Microcoded-style Moore control FSM: fetch, decode, operand fetch and up to three execute states.
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes trap into HALT and set the sticky o_illegal flag.
module control_unit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_stall,
  input  logic [7:0] i_ir,
  output logic [3:0] o_transfer_cmd,
  output logic       o_inc_pc,
  output logic [1:0] o_inc_dec_sp,
  output logic       o_alu_calculate,
  output logic       o_alu_res_to_ap,
  output logic       o_reset_ir,
  output logic       o_halted,
  output logic       o_illegal
);

  typedef enum logic [3:0] {
    F_ADDR, F_READ, F_IR, DEC, OP_ADDR, OP_READ, EX1, EX2, EX3, HALT
  } state_t;

  typedef enum logic [3:0] {
    K_NOP, K_HALT, K_IMM, K_DIRECT, K_STORE, K_PUSH, K_ALU, K_JUMP, K_SYS, K_UNDEF
  } kind_t;

  function automatic kind_t classify(input logic [7:0] op);
    kind_t k;
    if (op == 8'h00)                                          k = K_NOP;
    else if (op == 8'hFF)                                     k = K_HALT;
    else if (op inside {8'h11, 8'h13, 8'h14, 8'h1E, 8'hC1})   k = K_IMM;
    else if (op inside {8'h19, 8'h1B})                        k = K_DIRECT;
    else if (op inside {8'h21, 8'h23})                        k = K_STORE;
    else if (op inside {8'h2C, 8'h2E})                        k = K_PUSH;
    else if (op inside {[8'h30:8'h4F], [8'h60:8'h8F], 8'h50, 8'h90}) k = K_ALU;
    else if (op inside {8'hA1, 8'hA5, 8'hA9, 8'hB0})          k = K_JUMP;
    else if (op inside {8'hC0, 8'hD0, 8'hE0})                 k = K_SYS;
    else                                                      k = K_UNDEF;
    return k;
  endfunction

  state_t state;
  kind_t  kind;

  assign kind = classify(i_ir);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= F_ADDR;
    end else if (!i_stall) begin
      case (state)
        F_ADDR:  state <= F_READ;
        F_READ:  state <= F_IR;
        F_IR:    state <= DEC;
        DEC: begin
          case (kind)
            K_NOP:         state <= F_ADDR;
            K_HALT:        state <= HALT;
            K_PUSH, K_SYS: state <= EX1;
            K_ALU:         state <= (i_ir == 8'h50 || i_ir == 8'h90) ? EX1 : OP_ADDR;
`ifdef CU_ILLEGAL_TRAP_EN
            K_UNDEF:       state <= HALT;
`else
            K_UNDEF:       state <= F_ADDR;
`endif
            default:       state <= OP_ADDR;
          endcase
        end
        OP_ADDR: state <= OP_READ;
        OP_READ: state <= EX1;
        EX1:     state <= (kind inside {K_DIRECT, K_STORE, K_PUSH, K_ALU}) ? EX2 : F_ADDR;
        EX2:     state <= (kind inside {K_DIRECT, K_STORE, K_PUSH}) ? EX3 : F_ADDR;
        EX3:     state <= F_ADDR;
        HALT:    state <= HALT;
        default: state <= F_ADDR;
      endcase
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      illegal_q <= 1'b0;
    else if (!i_stall && state == DEC && kind == K_UNDEF)
      illegal_q <= 1'b1;
  end

  assign o_illegal = illegal_q & ~i_rst;
`else
  assign o_illegal = 1'b0;
`endif

  // Reset forces everything low; stall suppresses strobes but not the HALT status.
  always_comb begin
    o_transfer_cmd  = '0;
    o_inc_pc        = 1'b0;
    o_inc_dec_sp    = '0;
    o_alu_calculate = 1'b0;
    o_alu_res_to_ap = 1'b0;
    o_reset_ir      = 1'b0;
    o_halted        = 1'b0;
    if (!i_rst) begin
      o_halted = (state == HALT);
      if (!i_stall) begin
        case (state)
          F_ADDR: begin
            o_transfer_cmd = 4'h1;
            o_reset_ir     = 1'b1;
          end
          F_READ: begin
            o_transfer_cmd = 4'h2;
            o_inc_pc       = 1'b1;
          end
          F_IR:    o_transfer_cmd = 4'h3;
          OP_ADDR: o_transfer_cmd = 4'h1;
          OP_READ: begin
            o_transfer_cmd = 4'h2;
            o_inc_pc       = 1'b1;
          end
          EX1: begin
            case (kind)
              K_IMM:             o_transfer_cmd = 4'h5;
              K_DIRECT, K_STORE: o_transfer_cmd = 4'h4;
              K_PUSH:            o_transfer_cmd = 4'h7;
              K_JUMP:            o_transfer_cmd = 4'hB;
              K_SYS:             o_transfer_cmd = i_ir[7:4] + 4'h0;
              K_ALU: begin
                o_alu_calculate = 1'b1;
                o_alu_res_to_ap = i_ir[1];
              end
              default: ;
            endcase
          end
          EX2: begin
            case (kind)
              K_DIRECT:         o_transfer_cmd = 4'h2;
              K_STORE, K_PUSH:  o_transfer_cmd = 4'h8;
              K_ALU: begin
                o_transfer_cmd  = 4'hA;
                o_alu_res_to_ap = i_ir[1];
              end
              default: ;
            endcase
          end
          EX3: begin
            case (kind)
              K_DIRECT:        o_transfer_cmd = 4'h5;
              K_STORE:         o_transfer_cmd = 4'h9;
              K_PUSH: begin
                o_transfer_cmd = 4'h9;
                o_inc_dec_sp   = 2'b10;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues hand-computed per-cycle outputs, a monitor compares them.
module tb_control_unit;

  typedef struct packed {
    logic [3:0] cmd;
    logic       pc;
    logic [1:0] sp;
    logic       calc;
    logic       ap;
    logic       rir;
    logic       halt;
    logic       ill;
  } out_t;

  typedef struct {
    out_t  exp;
    string name;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic [7:0] ir = 8'h00;
  logic [3:0] transfer_cmd;
  logic       inc_pc;
  logic [1:0] inc_dec_sp;
  logic       alu_calculate;
  logic       alu_res_to_ap;
  logic       reset_ir;
  logic       halted;
  logic       illegal;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  control_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_ir           (ir),
    .o_transfer_cmd (transfer_cmd),
    .o_inc_pc       (inc_pc),
    .o_inc_dec_sp   (inc_dec_sp),
    .o_alu_calculate(alu_calculate),
    .o_alu_res_to_ap(alu_res_to_ap),
    .o_reset_ir     (reset_ir),
    .o_halted       (halted),
    .o_illegal      (illegal)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [3:0] cmd, input logic pc, input logic [1:0] sp,
                              input logic calc, input logic ap, input logic rir,
                              input logic halt, input logic ill);
    return '{cmd: cmd, pc: pc, sp: sp, calc: calc, ap: ap, rir: rir, halt: halt, ill: ill};
  endfunction

  function automatic out_t c(input logic [3:0] cmd);
    return mk(cmd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic step(input logic r, input logic s, input logic [7:0] op,
                      input out_t e, input string name);
    @(posedge clk);
    #1;
    rst   = r;
    stall = s;
    ir    = op;
    sb.push_back('{exp: e, name: name});
  endtask

  task automatic fetch(input logic [7:0] op, input string name);
    step(1'b0, 1'b0, op, mk(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), {name, " f_addr"});
    step(1'b0, 1'b0, op, mk(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), {name, " f_read"});
    step(1'b0, 1'b0, op, c(4'h3), {name, " f_ir"});
    step(1'b0, 1'b0, op, c(4'h0), {name, " dec"});
  endtask

  task automatic operand(input logic [7:0] op, input string name);
    step(1'b0, 1'b0, op, c(4'h1), {name, " op_addr"});
    step(1'b0, 1'b0, op, mk(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), {name, " op_read"});
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      item_t it;
      out_t  act;
      it  = sb.pop_front();
      act = '{cmd: transfer_cmd, pc: inc_pc, sp: inc_dec_sp, calc: alu_calculate,
              ap: alu_res_to_ap, rir: reset_ir, halt: halted, ill: illegal};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: actual cmd=%h pc=%b sp=%b calc=%b ap=%b rir=%b halt=%b ill=%b, required cmd=%h pc=%b sp=%b calc=%b ap=%b rir=%b halt=%b ill=%b",
                 it.name, act.cmd, act.pc, act.sp, act.calc, act.ap, act.rir, act.halt, act.ill,
                 it.exp.cmd, it.exp.pc, it.exp.sp, it.exp.calc, it.exp.ap, it.exp.rir, it.exp.halt, it.exp.ill);
      end
    end
  end

  initial begin
    out_t zero;
    out_t hlt;
    zero = c(4'h0);
    hlt  = mk(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    step(1'b1, 1'b0, 8'h00, zero, "reset");

    // NOP twice, the second with a one-cycle stall in F_READ
    fetch(8'h00, "nop1");
    step(1'b0, 1'b0, 8'h00, mk(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "nop2 f_addr");
    step(1'b0, 1'b1, 8'h00, zero, "nop2 stall f_read");
    step(1'b0, 1'b0, 8'h00, mk(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "nop2 f_read");
    step(1'b0, 1'b0, 8'h00, c(4'h3), "nop2 f_ir");
    step(1'b0, 1'b0, 8'h00, zero, "nop2 dec");

    // ALU with operand, AP bit clear and set
    fetch(8'h31, "alu31");
    operand(8'h31, "alu31");
    step(1'b0, 1'b0, 8'h31, mk(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "alu31 ex1");
    step(1'b0, 1'b0, 8'h31, c(4'hA), "alu31 ex2");
    fetch(8'h62, "alu62");
    operand(8'h62, "alu62");
    step(1'b0, 1'b0, 8'h62, mk(4'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "alu62 ex1");
    step(1'b0, 1'b0, 8'h62, mk(4'hA, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "alu62 ex2");

    // ALU without operand
    fetch(8'h90, "alu90");
    step(1'b0, 1'b0, 8'h90, mk(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "alu90 ex1");
    step(1'b0, 1'b0, 8'h90, c(4'hA), "alu90 ex2");

    // push
    fetch(8'h2E, "push");
    step(1'b0, 1'b0, 8'h2E, c(4'h7), "push ex1");
    step(1'b0, 1'b0, 8'h2E, c(4'h8), "push ex2");
    step(1'b0, 1'b0, 8'h2E, mk(4'h9, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "push ex3");

    // direct load with three stalled cycles in EX2
    fetch(8'h19, "ld19");
    operand(8'h19, "ld19");
    step(1'b0, 1'b0, 8'h19, c(4'h4), "ld19 ex1");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 8'h19, zero, "ld19 stall ex2");
    step(1'b0, 1'b0, 8'h19, c(4'h2), "ld19 ex2");
    step(1'b0, 1'b0, 8'h19, c(4'h5), "ld19 ex3");

    // store
    fetch(8'h21, "st21");
    operand(8'h21, "st21");
    step(1'b0, 1'b0, 8'h21, c(4'h4), "st21 ex1");
    step(1'b0, 1'b0, 8'h21, c(4'h8), "st21 ex2");
    step(1'b0, 1'b0, 8'h21, c(4'h9), "st21 ex3");

    // immediate load and jump
    fetch(8'h11, "imm11");
    operand(8'h11, "imm11");
    step(1'b0, 1'b0, 8'h11, c(4'h5), "imm11 ex1");
    fetch(8'hA5, "jmpA5");
    operand(8'hA5, "jmpA5");
    step(1'b0, 1'b0, 8'hA5, c(4'hB), "jmpA5 ex1");

    // single-cycle system ops
    fetch(8'hC0, "sysC0");
    step(1'b0, 1'b0, 8'hC0, c(4'hC), "sysC0 ex1");
    fetch(8'hE0, "sysE0");
    step(1'b0, 1'b0, 8'hE0, c(4'hE), "sysE0 ex1");

    // reset mid-instruction, with stall also high
    fetch(8'h21, "midrst");
    step(1'b0, 1'b0, 8'h21, c(4'h1), "midrst op_addr");
    step(1'b1, 1'b1, 8'h21, zero, "midrst reset");
    fetch(8'h00, "after midrst");

    // halt, then leave only through reset
    fetch(8'hFF, "halt");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 8'hFF, hlt, "halt hold");
    step(1'b1, 1'b0, 8'hFF, zero, "halt reset");
    step(1'b0, 1'b0, 8'h00, mk(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "halt exit f_addr");
    step(1'b0, 1'b0, 8'h00, mk(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "halt exit f_read");
    step(1'b0, 1'b0, 8'h00, c(4'h3), "halt exit f_ir");
    step(1'b0, 1'b0, 8'h00, zero, "halt exit dec");

    // undefined opcode
    fetch(8'hF3, "undef");
`ifdef CU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 8'hF3, mk(4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), "undef trap");
`else
    step(1'b0, 1'b0, 8'hF3, mk(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "undef as nop");
`endif
    step(1'b1, 1'b0, 8'h00, zero, "undef reset");
    step(1'b0, 1'b0, 8'h00, mk(4'h1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "final f_addr");

    for (int i = 0; i < 5 && sb.size() != 0; i++)
      @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
